ssbiq_tx_sequencer: RTL and testbench

Burst controller that sits in front of `ssbiq_modulator` and drives all of its control inputs. It latches a transmit configuration on `start` and sequences the modulator through one of two burst types:
- **SSB mode:** a standby-to-carrier amplitude ramp-up, a hold, then a ramp-down.
- **QPSK mode:** a fixed preamble followed by a stream of 2-bit symbols taken over a valid/ready handshake.

It reports burst status and symbol underrun to the PS-side register block.

---
 rtl/ssbiq_tx_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_ssbiq_tx_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssbiq_tx_sequencer.sv
// Burst sequencer driving every ssbiq_modulator control input: an SSB amplitude ramp/hold/ramp,
// or a QPSK burst made of a fixed preamble followed by a valid/ready symbol stream.
module ssbiq_tx_sequencer #(
  parameter int NBITS        = 24,
  parameter int PREAMBLE_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              stop,
  input  logic              abort,
  input  logic [NBITS-7:0]  cfg_ssb_freq,
  input  logic [NBITS-11:0] cfg_delta_phase,
  input  logic [NBITS+2:0]  cfg_amplitude,
  input  logic [NBITS+2:0]  cfg_ramp_step,
  input  logic [15:0]       cfg_sym_period,
  input  logic [1:0]        sym_data,
  input  logic              sym_valid,
  input  logic              sym_last,
  output logic              sym_ready,
  output logic [NBITS-7:0]  ssb_freq,
  output logic [NBITS-11:0] delta_phase,
  output logic [NBITS+2:0]  amplitude,
  output logic              stdby,
  output logic              set_qpsk,
  output logic [NBITS+2:0]  qpsk_phase,
  output logic              busy,
  output logic              underrun
);
  localparam int AW = NBITS + 3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_UP   = 3'd1;
  localparam logic [2:0] S_ON   = 3'd2;
  localparam logic [2:0] S_DOWN = 3'd3;
  localparam logic [2:0] S_PRE  = 3'd4;
  localparam logic [2:0] S_DATA = 3'd5;

  localparam logic [7:0] LAST_PRE = 8'(PREAMBLE_LEN - 1);

  logic [2:0]        state_q, state_d;
  logic [AW-1:0]     amp_q, amp_d, tgt_q, tgt_d, step_q, step_d, phase_q, phase_d;
  logic [NBITS-7:0]  freq_q, freq_d;
  logic [NBITS-11:0] dph_q, dph_d;
  logic [15:0]       per_q, per_d, cnt_q, cnt_d;
  logic [7:0]        idx_q, idx_d;
  logic              last_q, last_d, und_q, und_d;
  logic              stdby_q, busy_q, setq_q;
  logic              slot_end;

  // Sum is one bit wider than the amplitude so a large step saturates at the target instead of wrapping.
  function automatic logic [AW-1:0] amp_up(input logic [AW-1:0] a, input logic [AW-1:0] s,
                                           input logic [AW-1:0] t);
    logic [AW:0] sum;
    sum = {1'b0, a} + {1'b0, s};
    if (s == '0 || sum >= {1'b0, t}) return t;
    return sum[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] amp_dn(input logic [AW-1:0] a, input logic [AW-1:0] s);
    return (s != '0 && a > s) ? a - s : '0;
  endfunction

  function automatic logic [AW-1:0] sym_ph(input logic [1:0] s);
    return {s, 1'b1, {NBITS{1'b0}}};
  endfunction

  assign slot_end  = (cnt_q == per_q - 16'd1);
  assign sym_ready = slot_end && ((state_q == S_PRE && idx_q == LAST_PRE) ||
                                  (state_q == S_DATA && !last_q));

  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    phase_d = phase_q;
    freq_d  = freq_q;
    dph_d   = dph_q;
    per_d   = per_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    und_d   = und_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          freq_d = cfg_ssb_freq;
          dph_d  = cfg_delta_phase;
          tgt_d  = cfg_amplitude;
          step_d = cfg_ramp_step;
          per_d  = (cfg_sym_period < 16'd2) ? 16'd2 : cfg_sym_period;
          und_d  = 1'b0;
          cnt_d  = '0;
          idx_d  = '0;
          last_d = 1'b0;
          if (!mode) begin
            amp_d   = amp_up('0, cfg_ramp_step, cfg_amplitude);
            state_d = (amp_d == cfg_amplitude) ? S_ON : S_UP;
          end else begin
            phase_d = sym_ph(2'd0);
            state_d = S_PRE;
          end
        end
        S_UP, S_ON: begin
          // stop wins over reaching the target; the first decrement lands on the stop edge
          if (stop) begin
            amp_d   = amp_dn(amp_q, step_q);
            state_d = (amp_d == '0) ? S_IDLE : S_DOWN;
          end else if (state_q == S_UP) begin
            amp_d = amp_up(amp_q, step_q, tgt_q);
            if (amp_d == tgt_q) state_d = S_ON;
          end
        end
        S_DOWN: begin
          amp_d = amp_dn(amp_q, step_q);
          if (amp_d == '0) state_d = S_IDLE;
        end
        S_PRE: if (slot_end) begin
          cnt_d = '0;
          if (idx_q == LAST_PRE) begin
            if (sym_valid) begin
              state_d = S_DATA;
              phase_d = sym_ph(sym_data);
              last_d  = sym_last;
            end else begin
              und_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            idx_d   = idx_q + 8'd1;
            phase_d = sym_ph({idx_d[0], 1'b0});
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        S_DATA: if (slot_end) begin
          cnt_d = '0;
          if (last_q) begin
            state_d = S_IDLE;
          end else if (sym_valid) begin
            phase_d = sym_ph(sym_data);
            last_d  = sym_last;
          end else begin
            und_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d == S_IDLE) begin
      amp_d   = '0;
      phase_d = '0;
      freq_d  = '0;
      dph_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      amp_q   <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      phase_q <= '0;
      freq_q  <= '0;
      dph_q   <= '0;
      per_q   <= 16'd2;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      und_q   <= 1'b0;
      stdby_q <= 1'b1;
      busy_q  <= 1'b0;
      setq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      amp_q   <= amp_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      freq_q  <= freq_d;
      dph_q   <= dph_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      und_q   <= und_d;
      stdby_q <= (state_d == S_IDLE);
      busy_q  <= (state_d != S_IDLE);
      setq_q  <= (state_d == S_PRE) || (state_d == S_DATA);
    end
  end

  assign ssb_freq    = freq_q;
  assign delta_phase = dph_q;
  assign amplitude   = amp_q;
  assign qpsk_phase  = phase_q;
  assign stdby       = stdby_q;
  assign busy        = busy_q;
  assign set_qpsk    = setq_q;
  assign underrun    = und_q;
endmodule

// File: tb/tb_ssbiq_tx_sequencer.sv
// Bench for ssbiq_tx_sequencer: burst-level reference model compared every cycle,
// directed bursts with literal expectations, then randomized traffic.
module tb_ssbiq_tx_sequencer;
  localparam int NBITS = 24;
  localparam int PL    = 8;
  localparam int AW    = NBITS + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0, mode = 1'b0, stop = 1'b0, abort = 1'b0;
  logic [NBITS-7:0]  cfg_ssb_freq = '0;
  logic [NBITS-11:0] cfg_delta_phase = '0;
  logic [AW-1:0]     cfg_amplitude = '0, cfg_ramp_step = '0;
  logic [15:0]       cfg_sym_period = 16'd4;
  logic [1:0]        sym_data = '0;
  logic              sym_valid = 1'b0, sym_last = 1'b0;
  logic              sym_ready, stdby, set_qpsk, busy, underrun;
  logic [NBITS-7:0]  ssb_freq;
  logic [NBITS-11:0] delta_phase;
  logic [AW-1:0]     amplitude, qpsk_phase;

  ssbiq_tx_sequencer #(.NBITS(NBITS), .PREAMBLE_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .stop(stop), .abort(abort),
    .cfg_ssb_freq(cfg_ssb_freq), .cfg_delta_phase(cfg_delta_phase),
    .cfg_amplitude(cfg_amplitude), .cfg_ramp_step(cfg_ramp_step),
    .cfg_sym_period(cfg_sym_period), .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_last(sym_last), .sym_ready(sym_ready), .ssb_freq(ssb_freq),
    .delta_phase(delta_phase), .amplitude(amplitude), .stdby(stdby), .set_qpsk(set_qpsk),
    .qpsk_phase(qpsk_phase), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Burst-level model: SSB tracks amplitude arithmetic; QPSK tracks elapsed clocks and accepted symbols.
  bit          m_busy = 1'b0, m_mode = 1'b0, m_dn = 1'b0, m_und = 1'b0;
  longint      m_amp = 0, m_tgt = 0, m_step = 0, m_freq = 0, m_dph = 0;
  int          m_P = 2, m_t = 0;
  logic [2:0]  m_q[$];

  function automatic longint ramp_up(input longint a);
    if (m_step == 0 || a + m_step >= m_tgt) return m_tgt;
    return a + m_step;
  endfunction

  function automatic longint ramp_dn(input longint a);
    return (m_step != 0 && a > m_step) ? a - m_step : 0;
  endfunction

  function automatic bit exp_ready();
    int idx;
    if (!(m_busy && m_mode)) return 1'b0;
    idx = m_t / m_P;
    if (m_t % m_P != m_P - 1 || idx < PL - 1) return 1'b0;
    if (idx >= PL) return !m_q[idx-PL][2];
    return 1'b1;
  endfunction

  function automatic longint exp_phase();
    int idx;
    int s;
    if (!(m_busy && m_mode)) return 0;
    idx = m_t / m_P;
    if (idx < PL) s = (idx % 2 == 1) ? 2 : 0;
    else if (idx - PL < m_q.size()) s = int'(m_q[idx-PL][1:0]);
    else return -1;
    return longint'(2 * s + 1) << NBITS;
  endfunction

  task automatic model_step();
    bit rdy;
    int idx;
    rdy = exp_ready();
    if (abort) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1; m_und = 1'b0; m_mode = mode; m_dn = 1'b0;
        m_freq = longint'(cfg_ssb_freq); m_dph = longint'(cfg_delta_phase);
        m_tgt = longint'(cfg_amplitude); m_step = longint'(cfg_ramp_step);
        m_P = (cfg_sym_period < 16'd2) ? 2 : int'(cfg_sym_period);
        m_t = 0; m_q.delete(); m_amp = 0;
        if (!mode) m_amp = ramp_up(0);
      end
    end else if (!m_mode) begin
      if (m_dn || stop) begin
        m_dn = 1'b1;
        m_amp = ramp_dn(m_amp);
        if (m_amp == 0) m_busy = 1'b0;
      end else begin
        m_amp = ramp_up(m_amp);
      end
    end else begin
      idx = m_t / m_P;
      if (m_t % m_P == m_P - 1 && idx >= PL && m_q[idx-PL][2]) m_busy = 1'b0;
      else if (rdy && !sym_valid) begin m_und = 1'b1; m_busy = 1'b0; end
      else begin
        if (rdy) m_q.push_back({sym_last, sym_data});
        m_t++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stdby", 64'(stdby), 64'(!m_busy));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("set_qpsk", 64'(set_qpsk), 64'(m_busy && m_mode));
      chk("amplitude", 64'(amplitude), 64'((m_busy && !m_mode) ? m_amp : 0));
      chk("qpsk_phase", 64'(qpsk_phase), 64'(exp_phase()));
      chk("sym_ready", 64'(sym_ready), 64'(exp_ready()));
      chk("ssb_freq", 64'(ssb_freq), 64'(m_busy ? m_freq : 0));
      chk("delta_phase", 64'(delta_phase), 64'(m_busy ? m_dph : 0));
      chk("underrun", 64'(underrun), 64'(m_und));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    int n;
    int si;
    int bcount;
    bit r;
    logic [1:0] sl [3];
    logic [AW-1:0] ph [1:48];

    #12;
    chk("rst_stdby", 64'(stdby), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_amp", 64'(amplitude), 64'(0));
    chk("rst_ready", 64'(sym_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // SSB ramp up, hold, stop, ramp down
    cfg_ssb_freq = 18'h2A5A5; cfg_delta_phase = 14'h1234;
    cfg_amplitude = 27'h1F00000; cfg_ramp_step = 27'h400000; mode = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk("ssb_up1", 64'(amplitude), 64'h400000);
    chk("ssb_busy1", 64'(busy), 64'(1));
    chk("ssb_freq_out", 64'(ssb_freq), 64'h2A5A5);
    for (int k = 2; k <= 20; k++) begin
      cyc();
      if (k == 7)  chk("ssb_up7", 64'(amplitude), 64'h1C00000);
      if (k == 8)  chk("ssb_up8", 64'(amplitude), 64'h1F00000);
      if (k == 20) chk("ssb_hold", 64'(amplitude), 64'h1F00000);
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("ssb_dn1", 64'(amplitude), 64'h1B00000);
    n = 1;
    while (stdby !== 1'b1 && n < 40) begin cyc(); n++; end
    chk("ssb_dn_len", 64'(n), 64'(8));
    chk("ssb_idle_amp", 64'(amplitude), 64'(0));

    // QPSK burst: P=4, data 1,3,2 with last on 2
    sl[0] = 2'd1; sl[1] = 2'd3; sl[2] = 2'd2;
    mode = 1'b1; cfg_sym_period = 16'd4;
    si = 0; bcount = 0;
    sym_valid = 1'b1; sym_data = sl[0]; sym_last = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      ph[c] = qpsk_phase;
      if (busy === 1'b1) bcount++;
      r = sym_ready;
      cyc();
      if (r && si < 3) si++;
      if (si < 3) begin
        sym_valid = 1'b1; sym_data = sl[si]; sym_last = (si == 2);
      end else begin
        sym_valid = 1'b0; sym_data = 2'd0; sym_last = 1'b0;
      end
    end
    chk("qp_c1", 64'(ph[1]), 64'h1000000);
    chk("qp_c5", 64'(ph[5]), 64'h5000000);
    chk("qp_c32", 64'(ph[32]), 64'h5000000);
    chk("qp_c33", 64'(ph[33]), 64'h3000000);
    chk("qp_c36", 64'(ph[36]), 64'h3000000);
    chk("qp_c37", 64'(ph[37]), 64'h7000000);
    chk("qp_c41", 64'(ph[41]), 64'h5000000);
    chk("qp_c44", 64'(ph[44]), 64'h5000000);
    chk("qp_c45", 64'(ph[45]), 64'h0);
    chk("qp_busy_len", 64'(bcount), 64'(44));

    // Underrun at first data ready, with period 0 treated as 2
    cfg_sym_period = 16'd0; sym_valid = 1'b0; mode = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    n = 1;
    while (stdby !== 1'b1 && n < 100) begin
      cyc(); n++;
      if (n == 2) chk("p0_c2", 64'(qpsk_phase), 64'h1000000);
      if (n == 3) chk("p0_c3", 64'(qpsk_phase), 64'h5000000);
    end
    chk("urun_len", 64'(n), 64'(17));
    chk("urun_flag", 64'(underrun), 64'(1));

    // Next start clears underrun; abort mid-ramp
    mode = 1'b0; cfg_amplitude = 27'h1000000; cfg_ramp_step = 27'h100000;
    start = 1'b1; cyc(); start = 1'b0;
    chk("urun_clear", 64'(underrun), 64'(0));
    cyc(); cyc();
    chk("abort_pre", 64'(amplitude), 64'h300000);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("abort_amp", 64'(amplitude), 64'(0));
    chk("abort_stdby", 64'(stdby), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));

    // Step 0: instant jump and instant drop
    cfg_amplitude = 27'h123456; cfg_ramp_step = 27'h0;
    start = 1'b1; cyc(); start = 1'b0;
    chk("step0_up", 64'(amplitude), 64'h123456);
    cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("step0_dn", 64'(amplitude), 64'(0));
    chk("step0_idle", 64'(stdby), 64'(1));

    // Asynchronous reset mid-DATA
    mode = 1'b1; cfg_sym_period = 16'd3; sym_valid = 1'b1; sym_last = 1'b0; sym_data = 2'd3;
    cfg_ssb_freq = 18'h155; cfg_delta_phase = 14'h2AA;
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 30; k++) cyc();
    chk("ar_pre_phase", 64'(qpsk_phase), 64'h7000000);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_stdby", 64'(stdby), 64'(1));
    chk("ar_busy", 64'(busy), 64'(0));
    chk("ar_setq", 64'(set_qpsk), 64'(0));
    chk("ar_phase", 64'(qpsk_phase), 64'(0));
    chk("ar_freq", 64'(ssb_freq), 64'(0));
    chk("ar_dph", 64'(delta_phase), 64'(0));
    chk("ar_ready", 64'(sym_ready), 64'(0));
    chk("ar_urun", 64'(underrun), 64'(0));
    m_busy = 1'b0; m_und = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      start = ($urandom_range(0, 3) == 0);
      mode  = 1'($urandom_range(0, 1));
      stop  = ($urandom_range(0, 39) == 0);
      abort = ($urandom_range(0, 199) == 0);
      cfg_ssb_freq    = 18'($urandom);
      cfg_delta_phase = 14'($urandom);
      cfg_amplitude   = AW'($urandom);
      case ($urandom_range(0, 9))
        0:       cfg_ramp_step = '0;
        1:       cfg_ramp_step = AW'($urandom) | 27'h4000000;
        default: cfg_ramp_step = AW'(cfg_amplitude / AW'($urandom_range(1, 40))) + 27'd1;
      endcase
      cfg_sym_period = 16'($urandom_range(0, 4));
      sym_valid = ($urandom_range(0, 19) != 0);
      sym_data  = 2'($urandom_range(0, 3));
      sym_last  = ($urandom_range(0, 5) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
